// File: rtl/store_narrow_unit_if.sv
// Store request / data memory bundle for store_narrow_unit.
// slave: the store unit itself; master: requester plus memory side.
interface store_narrow_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ReqValid;
  logic              ReqReady;
  logic [ADDR_W-1:0] ReqAddr;
  logic [31:0]       ReqData;
  logic [1:0]        ReqSize;
  logic              Done;
  logic              Err;
  logic              MemRd;
  logic              MemWr;
  logic [ADDR_W-3:0] MemAddr;
  logic [31:0]       MemWData;
  logic [31:0]       MemRData;
  logic              MemRValid;
  logic              MemAck;
  logic [3:0]        ByteEn;

  modport slave (
    input  ReqValid, ReqAddr, ReqData, ReqSize, MemRData, MemRValid, MemAck,
    output ReqReady, Done, Err, MemRd, MemWr, MemAddr, MemWData, ByteEn
  );

  modport master (
    output ReqValid, ReqAddr, ReqData, ReqSize, MemRData, MemRValid, MemAck,
    input  ReqReady, Done, Err, MemRd, MemWr, MemAddr, MemWData, ByteEn
  );
endinterface

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit store to byte/half/word, aligns it
// into its byte lanes and commits it to a word memory without byte enables
// (read-modify-write for narrow stores).
// Optional macro MISALIGN_TRAP_EN: misaligned stores are rejected with Err
// instead of being forced to alignment.
module store_narrow_unit #(
  parameter int ADDR_W = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  store_narrow_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [1:0]        req_lane;
  logic [3:0]        req_be;
  logic [31:0]       req_data;
  logic              req_word;
  logic [31:0]       be_mask;

`ifdef MISALIGN_TRAP_EN
  logic              req_misalign;
  logic              err_q, err_d;
`endif

  // Request decode: data is replicated across lanes; only ByteEn lanes survive the merge.
  always_comb begin
    req_lane = 2'b00;
    req_be   = 4'b1111;
    req_data = bus.ReqData;
    req_word = 1'b1;
    case (bus.ReqSize)
      2'b00: begin
        req_lane = bus.ReqAddr[1:0];
        req_be   = 4'b0001 << req_lane;
        req_data = {4{bus.ReqData[7:0]}};
        req_word = 1'b0;
      end
      2'b01: begin
        req_lane = {bus.ReqAddr[1], 1'b0};
        req_be   = bus.ReqAddr[1] ? 4'b1100 : 4'b0011;
        req_data = {2{bus.ReqData[15:0]}};
        req_word = 1'b0;
      end
      default: begin
        req_lane = 2'b00;
        req_be   = 4'b1111;
        req_data = bus.ReqData;
        req_word = 1'b1;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    case (bus.ReqSize)
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = bus.ReqAddr[0];
      default: req_misalign = |bus.ReqAddr[1:0];
    endcase
`endif
  end

  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  // Next-state: accept in IDLE, merge read word in READ, hold write until ack.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          waddr_d = bus.ReqAddr[ADDR_W-1:2];
          wdata_d = req_data;
          be_d    = req_be;
          state_d = req_word ? WRITE : READ;
`ifdef MISALIGN_TRAP_EN
          err_d   = 1'b0;
          if (req_misalign) begin
            err_d   = 1'b1;
            be_d    = 4'b0000;
            state_d = DONE;
          end
`endif
        end
      end
      READ: begin
        if (bus.MemRValid) begin
          wdata_d = (bus.MemRData & ~be_mask) | (wdata_q & be_mask);
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.MemAck) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Rejection flag for the current store, reported alongside Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign bus.Err = err_q && (state_q == DONE);
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.ReqReady = (state_q == IDLE);
  assign bus.Done     = (state_q == DONE);
  assign bus.MemRd    = (state_q == READ);
  assign bus.MemWr    = (state_q == WRITE);
  assign bus.MemAddr  = waddr_q;
  assign bus.MemWData = wdata_q;
  assign bus.ByteEn   = (state_q == WRITE) ? be_q : 4'b0000;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: byte-array reference memory, directed and
// random stores with variable memory latency, reset abandonment.
module tb_store_narrow_unit;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  store_narrow_unit_if #(.ADDR_W(32)) bus();

  store_narrow_unit #(.ADDR_W(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_bytes [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Caller is positioned at a negedge with ReqReady expected high.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input int rd_lat, input int wr_lat,
                           input string tag);
    int nb, a, base, w, exp_rd, exp_wr, exp_done;
    int rd_n, wr_n, done_c;
    bit mis, exp_err, err_s, overlap, stable, addr_ok;
    logic [3:0]  exp_be, be_s;
    logic [31:0] wd_s;
    logic [29:0] wa_s;

    // reference: byte-granular memory update
    a       = int'(addr);
    nb      = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis     = (a % nb) != 0;
    exp_err = TRAP && mis;
    base    = a - (a % nb);
    w       = base / 4;
    exp_be  = 4'b0000;
    if (!exp_err) begin
      for (int i = 0; i < nb; i++) begin
        ref_bytes[base+i]      = data[8*i +: 8];
        exp_be[(base + i) % 4] = 1'b1;
      end
    end
    exp_rd   = (exp_err || nb == 4) ? 0 : rd_lat + 1;
    exp_wr   = exp_err ? 0 : wr_lat + 1;
    exp_done = exp_err ? 1 : exp_rd + exp_wr + 1;

    chk({tag, " ready"}, {31'b0, bus.ReqReady}, 32'd1);
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = addr;
    bus.ReqData  = data;
    bus.ReqSize  = size;
    @(posedge Clk);
    @(negedge Clk);
    // junk on the request port must be ignored while busy
    bus.ReqValid = 1'b0;
    bus.ReqAddr  = $urandom_range(0, 255);
    bus.ReqData  = $urandom;
    bus.ReqSize  = 2'($urandom_range(0, 3));

    rd_n = 0; wr_n = 0; done_c = 0; err_s = 0;
    overlap = 0; stable = 1; addr_ok = 1;
    wd_s = '0; be_s = '0; wa_s = '0;
    for (int c = 1; c <= 300; c++) begin
      bus.MemRValid = 1'b0;
      bus.MemAck    = 1'b0;
      bus.MemRData  = $urandom;
      if (bus.MemRd && bus.MemWr) overlap = 1;
      if (bus.MemRd) begin
        rd_n++;
        if (bus.MemAddr != 30'(w)) addr_ok = 0;
        if (rd_n > rd_lat) begin
          bus.MemRValid = 1'b1;
          bus.MemRData  = mem[bus.MemAddr[5:0]];
        end
      end
      if (bus.MemWr) begin
        wr_n++;
        if (wr_n == 1) begin
          wd_s = bus.MemWData; be_s = bus.ByteEn; wa_s = bus.MemAddr;
        end else if (bus.MemWData !== wd_s || bus.ByteEn !== be_s || bus.MemAddr !== wa_s) begin
          stable = 0;
        end
        if (wr_n > wr_lat) begin
          bus.MemAck = 1'b1;
          mem[bus.MemAddr[5:0]] = bus.MemWData;
        end
      end
      if (bus.Done) begin
        done_c = c;
        err_s  = bus.Err;
        break;
      end
      @(negedge Clk);
    end

    chk({tag, " done_cycle"}, done_c, exp_done);
    chk({tag, " err"}, {31'b0, err_s}, {31'b0, exp_err});
    chk({tag, " rd_cycles"}, rd_n, exp_rd);
    chk({tag, " wr_cycles"}, wr_n, exp_wr);
    chk({tag, " rd_wr_overlap"}, {31'b0, overlap}, 32'd0);
    chk({tag, " wr_stable"}, {31'b0, stable}, 32'd1);
    chk({tag, " rd_addr"}, {31'b0, addr_ok}, 32'd1);
    if (!exp_err) begin
      chk({tag, " wdata"}, wd_s, ref_word(w));
      chk({tag, " byte_en"}, {28'b0, be_s}, {28'b0, exp_be});
      chk({tag, " wr_addr"}, {2'b0, wa_s}, w);
    end
    chk({tag, " mem_word"}, mem[w], ref_word(w));

    @(negedge Clk);
    chk({tag, " done_pulse"}, {31'b0, bus.Done}, 32'd0);
    chk({tag, " ready_after"}, {31'b0, bus.ReqReady}, 32'd1);
  endtask

  initial begin
    bit wr_seen;
    Reset_n       = 1'b0;
    bus.ReqValid  = 1'b0;
    bus.ReqAddr   = '0;
    bus.ReqData   = '0;
    bus.ReqSize   = '0;
    bus.MemRData  = '0;
    bus.MemRValid = 1'b0;
    bus.MemAck    = 1'b0;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);

    #1;
    chk("rst ready", {31'b0, bus.ReqReady}, 32'd1);
    chk("rst done",  {31'b0, bus.Done}, 32'd0);
    chk("rst err",   {31'b0, bus.Err}, 32'd0);
    chk("rst memrd", {31'b0, bus.MemRd}, 32'd0);
    chk("rst memwr", {31'b0, bus.MemWr}, 32'd0);
    chk("rst memaddr", {2'b0, bus.MemAddr}, 32'd0);
    chk("rst wdata", bus.MemWData, 32'd0);
    chk("rst byteen", {28'b0, bus.ByteEn}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // directed cases
    run_store(32'h10, 32'hDEADBEEF, 2'b10, 0, 0, "word10");
    chk("word10 mem", mem[4], 32'hDEADBEEF);
    set_word(4, 32'h11223344);
    run_store(32'h13, 32'h123456AB, 2'b00, 0, 0, "byte13");
    chk("byte13 mem", mem[4], 32'hAB223344);
    set_word(8, 32'hAAAABBBB);
    run_store(32'h22, 32'hFFFF8001, 2'b01, 0, 3, "half22");
    chk("half22 mem", mem[8], 32'h8001BBBB);
    set_word(1, 32'h01020304);
    run_store(32'h05, 32'h0000CAFE, 2'b01, 1, 1, "half05");
    chk("half05 mem", mem[1], TRAP ? 32'h01020304 : 32'h0102CAFE);
    run_store(32'h07, 32'h89ABCDEF, 2'b11, 0, 0, "size3_07");
    set_word(16, 32'h00000000);
    run_store(32'h40, 32'h00000011, 2'b00, 0, 0, "b2b_40");
    run_store(32'h41, 32'h00000022, 2'b00, 0, 0, "b2b_41");
    chk("b2b mem", mem[16], 32'h00002211);

    // reset during a stalled read: no write may follow
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = 32'h30;
    bus.ReqData  = 32'h55;
    bus.ReqSize  = 2'b00;
    @(posedge Clk);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    chk("rstmid memrd_on", {31'b0, bus.MemRd}, 32'd1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("rstmid memrd_off", {31'b0, bus.MemRd}, 32'd0);
    chk("rstmid memwr_off", {31'b0, bus.MemWr}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("rstmid ready", {31'b0, bus.ReqReady}, 32'd1);
    wr_seen = 0;
    repeat (5) begin
      @(negedge Clk);
      if (bus.MemWr || bus.MemRd) wr_seen = 1;
    end
    chk("rstmid no_access", {31'b0, wr_seen}, 32'd0);
    chk("rstmid mem", mem[12], ref_word(12));

    // random stores with random memory latency
    for (int n = 0; n < 40; n++) begin
      run_store(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
    for (int i = 0; i < 64; i++) chk("final mem", mem[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
